// File: rtl/neuron_feeder.sv
// Sequencer feeding one ROM-resident image into NeuronCalculator, then capturing its cat/not-cat bit.
// Latency: start to done is NUM_WORDS+7 cycles. No backpressure: ROM and calculator accept one word per cycle.
module neuron_feeder #(
  parameter int DATA_WIDTH       = 24,
  parameter int Addr_Depth       = 12,
  parameter int Weight_Percision = 5,
  parameter int NUM_WORDS        = 4096
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  output logic [Addr_Depth-1:0]         mem_addr,
  output logic                          mem_rd,
  input  logic [DATA_WIDTH-1:0]         pixel_rdata,
  input  logic [3*Weight_Percision-1:0] weight_rdata,
  output logic [DATA_WIDTH-1:0]         x,
  output logic [3*Weight_Percision-1:0] w,
  output logic                          calc_enable,
  output logic                          calc_reset,
  output logic                          get_result,
  input  logic                          neuron_calculator_out,
  output logic                          busy,
  output logic                          done,
  output logic                          cat_detected
);

  // One extra counter bit lets NUM_WORDS == 2**Addr_Depth terminate instead of wrapping.
  localparam int CW = Addr_Depth + 1;
  localparam logic [CW-1:0] N_WORDS  = CW'(NUM_WORDS);
  localparam logic [CW-1:0] END_CNT  = CW'(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_SETTLE,
    S_RESULT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_p1;

  assign cnt_p1 = cnt + CW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      x            <= '0;
      w            <= '0;
      calc_enable  <= 1'b0;
      calc_reset   <= 1'b0;
      get_result   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cat_detected <= 1'b0;
    end else begin
      calc_reset  <= 1'b0;
      get_result  <= 1'b0;
      done        <= 1'b0;
      // A read issued last cycle returns data this cycle; enable leads x/w by one cycle.
      calc_enable <= mem_rd;
      x           <= calc_enable ? pixel_rdata  : '0;
      w           <= calc_enable ? weight_rdata : '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_CLEAR;
            calc_reset <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_CLEAR: begin
          state    <= S_STREAM;
          cnt      <= '0;
          mem_addr <= '0;
          mem_rd   <= 1'b1;
        end
        S_STREAM: begin
          cnt <= cnt_p1;
          if (cnt_p1 < N_WORDS) begin
            mem_addr <= cnt_p1[Addr_Depth-1:0];
            mem_rd   <= 1'b1;
          end else begin
            mem_addr <= '0;
            mem_rd   <= 1'b0;
          end
          // Two cycles past the last address the final word has left the x/w registers.
          if (cnt == END_CNT) begin
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          state      <= S_RESULT;
          get_result <= 1'b1;
        end
        S_RESULT: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          state        <= S_DONE;
          cat_detected <= neuron_calculator_out;
          done         <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_feeder.sv
// Drives neuron_feeder against ROM and calculator models; expected results are queued per image.
module tb_neuron_feeder;

  localparam int DW   = 24;
  localparam int AD   = 12;
  localparam int WP   = 5;
  localparam int N    = 4;
  localparam int BIAS = 0;

  logic            clock;
  logic            reset;
  logic            start;
  logic [AD-1:0]   mem_addr;
  logic            mem_rd;
  logic [DW-1:0]   pixel_rdata;
  logic [3*WP-1:0] weight_rdata;
  logic [DW-1:0]   x;
  logic [3*WP-1:0] w;
  logic            calc_enable, calc_reset, get_result, calc_out;
  logic            busy, done, cat_detected;

  logic            start_b;
  logic [AD-1:0]   mem_addr_b;
  logic            mem_rd_b;
  logic [DW-1:0]   pixel_rdata_b;
  logic [3*WP-1:0] weight_rdata_b;
  logic [DW-1:0]   x_b;
  logic [3*WP-1:0] w_b;
  logic            calc_enable_b, calc_reset_b, get_result_b, calc_out_b;
  logic            busy_b, done_b, cat_detected_b;

  logic [3*WP-1:0] wword;
  logic            en_q;
  int              acc;
  int              checks = 0;
  int              errors = 0;
  logic            sb[$];

  neuron_feeder #(.DATA_WIDTH(DW), .Addr_Depth(AD), .Weight_Percision(WP), .NUM_WORDS(N)) dut (
    .clock(clock), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_rd(mem_rd),
    .pixel_rdata(pixel_rdata), .weight_rdata(weight_rdata),
    .x(x), .w(w), .calc_enable(calc_enable), .calc_reset(calc_reset),
    .get_result(get_result), .neuron_calculator_out(calc_out),
    .busy(busy), .done(done), .cat_detected(cat_detected)
  );

  neuron_feeder #(.DATA_WIDTH(DW), .Addr_Depth(AD), .Weight_Percision(WP), .NUM_WORDS(4096)) dut_big (
    .clock(clock), .reset(reset), .start(start_b),
    .mem_addr(mem_addr_b), .mem_rd(mem_rd_b),
    .pixel_rdata(pixel_rdata_b), .weight_rdata(weight_rdata_b),
    .x(x_b), .w(w_b), .calc_enable(calc_enable_b), .calc_reset(calc_reset_b),
    .get_result(get_result_b), .neuron_calculator_out(calc_out_b),
    .busy(busy_b), .done(done_b), .cat_detected(cat_detected_b)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] pix_word(input logic [AD-1:0] a);
    return {8'd1, 8'd1, 8'(a + 12'd1)};
  endfunction

  function automatic int dot(input logic [DW-1:0] xv, input logic [3*WP-1:0] wv);
    int s = 0;
    for (int i = 0; i < 3; i++) begin
      logic [WP-1:0] wl;
      wl = wv[WP*i +: WP];
      s += int'(xv[8*i +: 8]) * int'($signed(wl));
    end
    return s;
  endfunction

  function automatic logic exp_cat();
    int s = 0;
    for (int k = 0; k < N; k++) s += dot(pix_word(AD'(k)), wword);
    return (s + BIAS) > 0;
  endfunction

  // ROM with 1-cycle registered read, plus a behavioural calculator that registers enable.
  always @(posedge clock) begin
    pixel_rdata  <= pix_word(mem_addr);
    weight_rdata <= wword;
    if (reset) begin
      en_q     <= 1'b0;
      calc_out <= 1'b0;
      acc      <= 0;
    end else begin
      en_q <= calc_enable;
      if (calc_reset)  acc <= 0;
      else if (en_q)   acc <= acc + dot(x, w);
      if (get_result)  calc_out <= (acc + BIAS) > 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int nimg, input bit hold, input bit noisy);
    int ndone = 0;
    int p;
    for (int i = 0; i < nimg; i++) sb.push_back(exp_cat());
    @(negedge clock);
    start = 1'b1;
    for (int c = 1; c <= 12 * nimg; c++) begin
      @(negedge clock);
      p = ((c - 1) % 12) + 1;
      if (noisy)                          start = (p >= 2 && p <= 10);
      else if (!hold || c >= 12*nimg - 1) start = 1'b0;
      check("calc_reset",  32'(calc_reset),  32'(p == 1));
      check("mem_rd",      32'(mem_rd),      32'(p >= 2 && p <= N + 1));
      if (p >= 2 && p <= N + 1) check("mem_addr", 32'(mem_addr), 32'(p - 2));
      check("calc_enable", 32'(calc_enable), 32'(p >= 3 && p <= N + 2));
      check("x", 32'(x), (p >= 4 && p <= N + 3) ? 32'(pix_word(AD'(p - 4))) : 32'd0);
      check("w", 32'(w), (p >= 4 && p <= N + 3) ? 32'(wword) : 32'd0);
      check("get_result",  32'(get_result),  32'(p == N + 5));
      check("done",        32'(done),        32'(p == N + 7));
      check("busy",        32'(busy),        32'(p >= 1 && p <= N + 7));
      if (done) begin
        ndone++;
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) check("cat_detected", 32'(cat_detected), 32'(sb.pop_front()));
      end
    end
    check("done_count", 32'(ndone), 32'(nimg));
  endtask

  initial begin
    int first_cyc, done_cyc, nrd, bad;
    logic [AD-1:0] exp_addr;
    clock = 1'b0; reset = 1'b1; start = 1'b0; start_b = 1'b0;
    wword = {5'd1, 5'd1, 5'd1};
    pixel_rdata_b = '0; weight_rdata_b = '0; calc_out_b = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cat",  32'(cat_detected), 0);
    check("rst_outs", 32'({mem_rd, calc_enable, calc_reset, get_result}), 0);
    check("rst_xw",   32'({x, w} != '0), 0);
    reset = 1'b0;
    @(negedge clock);

    run(1, 1'b0, 1'b0);                         // positive weights: cat
    wword = {5'b10000, 5'b10000, 5'b10000};
    run(1, 1'b0, 1'b0);                         // -16 weights: not cat
    wword = {5'd1, 5'd1, 5'd1};
    run(2, 1'b1, 1'b0);                         // start held high: back-to-back

    // Reset mid-STREAM, after a cat=1 result.
    @(negedge clock);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (c == 5) reset = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_x",    32'(x), 0);
    check("mid_rst_en",   32'(calc_enable), 0);
    check("mid_rst_cat",  32'(cat_detected), 0);
    check("mid_rst_done", 32'(done), 0);
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      check("post_rst_done", 32'(done), 0);
    end
    run(1, 1'b0, 1'b0);                         // recovers cleanly

    run(1, 1'b0, 1'b1);                         // start noise while busy
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      check("noise_no_done", 32'(done), 0);
      check("noise_idle",    32'(busy), 0);
    end
    check("sb_drained", 32'(sb.size()), 0);

    // Full-depth image: address counter must not wrap.
    first_cyc = -1; done_cyc = -1; nrd = 0; bad = 0; exp_addr = '0;
    @(negedge clock);
    start_b = 1'b1;
    for (int c = 1; c <= 4200; c++) begin
      @(negedge clock);
      start_b = 1'b0;
      if (mem_rd_b) begin
        if (first_cyc < 0) first_cyc = c;
        if (mem_addr_b != exp_addr) bad++;
        exp_addr = exp_addr + 12'd1;
        nrd++;
      end
      if (done_b) begin
        done_cyc = c;
        break;
      end
    end
    check("big_first_rd", 32'(first_cyc), 32'd2);
    check("big_rd_count", 32'(nrd), 32'd4096);
    check("big_addr_seq", 32'(bad), 32'd0);
    check("big_done_cyc", 32'(done_cyc), 32'd4103);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
